// File: rtl/lsu_align.sv
// Load/store alignment unit: lane placement, byte masks, load extension and
// optional two-beat splitting of accesses that straddle a bus word.
module lsu_align #(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int MISALIGN_SPLIT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              io_lsu_reqValid,
    output logic [ADDR_W-1:0] io_lsu_addr,
    output logic              io_lsu_wen,
    output logic [XLEN-1:0]   io_lsu_wdata,
    output logic [XLEN/8-1:0] io_lsu_wmask,
    output logic [1:0]        io_lsu_size,
    input  logic              io_lsu_respValid,
    input  logic [XLEN-1:0]   io_lsu_rdata
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t              state_q, state_d;
    logic                wen_q, wen_d;
    logic [1:0]          size_q, size_d;
    logic                sgn_q, sgn_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                cross_q, cross_d;
    logic [2*XLEN-1:0]   wd2_q, wd2_d;
    logic [2*NB-1:0]     mask2_q, mask2_d;
    logic [XLEN-1:0]     rdata0_q, rdata0_d;
    logic                resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]     resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;
    logic                bus_req_q, bus_req_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic                bus_wen_q, bus_wen_d;
    logic [XLEN-1:0]     bus_wdata_q, bus_wdata_d;
    logic [NB-1:0]       bus_wmask_q, bus_wmask_d;

    logic [OFF_W-1:0]    req_off_s;
    int                  req_bytes_s;
    logic                req_cross_s;
    logic                req_illegal_s;
    logic [2*XLEN-1:0]   req_wd2_s;
    logic [2*NB-1:0]     req_lmask_s;
    logic [2*NB-1:0]     req_mask2_s;
    logic [ADDR_W-1:0]   beat0_addr_s;

    // Shift the straddling pair down to the access offset, keep size bytes and extend.
    function automatic logic [XLEN-1:0] load_extract(input logic [2*XLEN-1:0] cat,
                                                      input logic [OFF_W-1:0]  off,
                                                      input logic [1:0]        size,
                                                      input logic              sgn);
        logic [2*XLEN-1:0] sh;
        logic [XLEN-1:0]   res;
        logic              msb;
        int                nbits;
        sh    = cat >> {off, 3'b000};
        nbits = 8 << size;
        if (nbits > XLEN) begin
            nbits = XLEN;
        end else begin
            nbits = nbits;
        end
        msb = sgn & sh[nbits-1];
        for (int i = 0; i < XLEN; i++) begin
            res[i] = (i < nbits) ? sh[i] : msb;
        end
        return res;
    endfunction

    assign req_ready       = (state_q == IDLE) && !reset;
    assign resp_valid      = resp_valid_q;
    assign resp_rdata      = resp_rdata_q;
    assign resp_err        = resp_err_q;
    assign io_lsu_reqValid = bus_req_q;
    assign io_lsu_addr     = bus_addr_q;
    assign io_lsu_wen      = bus_wen_q;
    assign io_lsu_wdata    = bus_wdata_q;
    assign io_lsu_wmask    = bus_wmask_q;
    assign io_lsu_size     = 2'(OFF_W);
    assign beat0_addr_s    = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Decode the incoming request into lane-positioned data/mask over two bus words.
    always_comb begin
        req_off_s     = req_addr[OFF_W-1:0];
        req_bytes_s   = 1 << req_size;
        req_cross_s   = (int'(req_off_s) + req_bytes_s) > NB;
        req_illegal_s = int'(req_size) > OFF_W;
        req_wd2_s     = {{XLEN{1'b0}}, req_wdata} << {req_off_s, 3'b000};
        for (int i = 0; i < 2*NB; i++) begin
            req_lmask_s[i] = (i < req_bytes_s);
        end
        req_mask2_s   = req_lmask_s << req_off_s;
    end

    // Next-state and registered-output logic for the access sequencer.
    always_comb begin
        state_d      = state_q;
        wen_d        = wen_q;
        size_d       = size_q;
        sgn_d        = sgn_q;
        addr_d       = addr_q;
        cross_d      = cross_q;
        wd2_d        = wd2_q;
        mask2_d      = mask2_q;
        rdata0_d     = rdata0_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = {XLEN{1'b0}};
        resp_err_d   = 1'b0;
        bus_req_d    = bus_req_q;
        bus_addr_d   = bus_addr_q;
        bus_wen_d    = bus_wen_q;
        bus_wdata_d  = bus_wdata_q;
        bus_wmask_d  = bus_wmask_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wen_d   = req_wen;
                    size_d  = req_size;
                    sgn_d   = req_signed;
                    addr_d  = req_addr;
                    cross_d = req_cross_s;
                    wd2_d   = req_wd2_s;
                    mask2_d = req_mask2_s;
                    if (req_illegal_s || (req_cross_s && (MISALIGN_SPLIT == 0))) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = BEAT0;
                        bus_req_d   = 1'b1;
                        bus_addr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        bus_wen_d   = req_wen;
                        bus_wdata_d = req_wd2_s[XLEN-1:0];
                        bus_wmask_d = req_wen ? req_mask2_s[NB-1:0] : {NB{1'b0}};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BEAT0: begin
                if (io_lsu_respValid) begin
                    bus_req_d = 1'b0;
                    rdata0_d  = io_lsu_rdata;
                    if (cross_q) begin
                        state_d = BEAT1;
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = wen_q ? {XLEN{1'b0}} :
                            load_extract({{XLEN{1'b0}}, io_lsu_rdata}, addr_q[OFF_W-1:0], size_q, sgn_q);
                    end
                end else begin
                    state_d = BEAT0;
                end
            end
            BEAT1: begin
                // First BEAT1 cycle is the mandatory request gap after beat 0.
                if (!bus_req_q) begin
                    bus_req_d   = 1'b1;
                    bus_addr_d  = beat0_addr_s + ADDR_W'(NB);
                    bus_wdata_d = wd2_q[2*XLEN-1:XLEN];
                    bus_wmask_d = wen_q ? mask2_q[2*NB-1:NB] : {NB{1'b0}};
                end else if (io_lsu_respValid) begin
                    bus_req_d    = 1'b0;
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = wen_q ? {XLEN{1'b0}} :
                        load_extract({io_lsu_rdata, rdata0_q}, addr_q[OFF_W-1:0], size_q, sgn_q);
                end else begin
                    state_d = BEAT1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            wen_q        <= 1'b0;
            size_q       <= 2'd0;
            sgn_q        <= 1'b0;
            addr_q       <= {ADDR_W{1'b0}};
            cross_q      <= 1'b0;
            wd2_q        <= {(2*XLEN){1'b0}};
            mask2_q      <= {(2*NB){1'b0}};
            rdata0_q     <= {XLEN{1'b0}};
            resp_valid_q <= 1'b0;
            resp_rdata_q <= {XLEN{1'b0}};
            resp_err_q   <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_addr_q   <= {ADDR_W{1'b0}};
            bus_wen_q    <= 1'b0;
            bus_wdata_q  <= {XLEN{1'b0}};
            bus_wmask_q  <= {NB{1'b0}};
        end else begin
            state_q      <= state_d;
            wen_q        <= wen_d;
            size_q       <= size_d;
            sgn_q        <= sgn_d;
            addr_q       <= addr_d;
            cross_q      <= cross_d;
            wd2_q        <= wd2_d;
            mask2_q      <= mask2_d;
            rdata0_q     <= rdata0_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            bus_req_q    <= bus_req_d;
            bus_addr_q   <= bus_addr_d;
            bus_wen_q    <= bus_wen_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_wmask_q  <= bus_wmask_d;
        end
    end
endmodule

// File: tb/tb_lsu_align.sv
// Scoreboard bench for lsu_align (XLEN=32): expected bus beats and responses are
// queued at issue time and consumed by a bus responder and a response monitor.
module tb_lsu_align;
    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_wen, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        io_lsu_reqValid, io_lsu_wen, io_lsu_respValid;
    logic [31:0] io_lsu_addr, io_lsu_wdata, io_lsu_rdata;
    logic [3:0]  io_lsu_wmask;
    logic [1:0]  io_lsu_size;

    logic        d0_req_valid, d0_req_ready, d0_resp_valid, d0_resp_err;
    logic [31:0] d0_resp_rdata, d0_addr, d0_wdata;
    logic        d0_bus_req, d0_bus_wen;
    logic [3:0]  d0_wmask;
    logic [1:0]  d0_size;
    logic        d0_bus_rv = 1'b0;
    logic [31:0] d0_bus_rd = 32'h0;

    typedef struct { logic [31:0] addr; logic wen; logic [31:0] wdata; logic [3:0] wmask; } beat_t;
    typedef struct { logic [31:0] rdata; logic err; } resp_t;
    beat_t       beat_q[$];
    logic [31:0] rd_q[$];
    resp_t       resp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_rv_cyc = -100;
    int bus_wait = 0;

    lsu_align #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .io_lsu_reqValid(io_lsu_reqValid), .io_lsu_addr(io_lsu_addr),
        .io_lsu_wen(io_lsu_wen), .io_lsu_wdata(io_lsu_wdata), .io_lsu_wmask(io_lsu_wmask),
        .io_lsu_size(io_lsu_size), .io_lsu_respValid(io_lsu_respValid), .io_lsu_rdata(io_lsu_rdata)
    );

    lsu_align #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(0)) dut0 (
        .clock(clock), .reset(reset),
        .req_valid(d0_req_valid), .req_ready(d0_req_ready), .req_wen(1'b0),
        .req_size(2'd1), .req_signed(1'b0), .req_addr(32'h0000_0103),
        .req_wdata(32'h0), .resp_valid(d0_resp_valid), .resp_rdata(d0_resp_rdata),
        .resp_err(d0_resp_err), .io_lsu_reqValid(d0_bus_req), .io_lsu_addr(d0_addr),
        .io_lsu_wen(d0_bus_wen), .io_lsu_wdata(d0_wdata), .io_lsu_wmask(d0_wmask),
        .io_lsu_size(d0_size), .io_lsu_respValid(d0_bus_rv), .io_lsu_rdata(d0_bus_rd)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Bus slave: after bus_wait idle cycles, acknowledge the beat and check it against the queue.
    initial begin
        int wait_cnt = 0;
        io_lsu_respValid = 1'b0;
        io_lsu_rdata     = 32'h0;
        forever begin
            @(negedge clock);
            io_lsu_respValid = 1'b0;
            if (reset || !io_lsu_reqValid) begin
                wait_cnt = 0;
            end else if (wait_cnt < bus_wait) begin
                wait_cnt++;
            end else begin
                wait_cnt = 0;
                if (beat_q.size() == 0) begin
                    check_eq("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    beat_t b;
                    b = beat_q.pop_front();
                    check_eq("beat_addr", io_lsu_addr, b.addr);
                    check_eq("beat_wen", io_lsu_wen, b.wen);
                    check_eq("beat_wmask", io_lsu_wmask, b.wmask);
                    if (b.wen) check_eq("beat_wdata", io_lsu_wdata, b.wdata);
                    io_lsu_rdata     = rd_q.pop_front();
                    io_lsu_respValid = 1'b1;
                    last_rv_cyc      = cyc;
                end
            end
        end
    end

    // Response monitor: every resp_valid must match the oldest expected response.
    initial begin
        forever begin
            @(negedge clock);
            if (resp_valid) begin
                if (resp_q.size() == 0) begin
                    check_eq("spurious_resp", 64'd1, 64'd0);
                end else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    check_eq("resp_rdata", resp_rdata, r.rdata);
                    check_eq("resp_err", resp_err, r.err);
                    if (!r.err) check_eq("resp_latency", cyc, last_rv_cyc + 1);
                end
            end
        end
    end

    task automatic exp_beat(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                            input logic [3:0] wmask, input logic [31:0] rdata);
        beat_t b;
        b.addr = addr; b.wen = wen; b.wdata = wdata; b.wmask = wmask;
        beat_q.push_back(b);
        rd_q.push_back(rdata);
    endtask

    task automatic exp_resp(input logic [31:0] rdata, input logic err);
        resp_t r;
        r.rdata = rdata; r.err = err;
        resp_q.push_back(r);
    endtask

    task automatic issue(input logic wen, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic has_beat);
        int n = 0;
        @(negedge clock);
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check_eq("req_ready", req_ready, 1'b1);
        req_valid = 1'b1; req_wen = wen; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        check_eq("reqValid_T1", io_lsu_reqValid, has_beat);
        if (!has_beat) check_eq("err_resp_T1", resp_valid, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while ((resp_q.size() != 0 || beat_q.size() != 0) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check_eq("drain_timeout", resp_q.size() + beat_q.size(), 0);
    endtask

    initial begin
        logic seen;
        reset = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; d0_req_valid = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("rst_resp_valid", resp_valid, 1'b0);
        check_eq("rst_resp_rdata", resp_rdata, 32'h0);
        check_eq("rst_resp_err", resp_err, 1'b0);
        check_eq("rst_reqValid", io_lsu_reqValid, 1'b0);
        check_eq("rst_addr", io_lsu_addr, 32'h0);
        check_eq("rst_wdata", io_lsu_wdata, 32'h0);
        check_eq("rst_wmask", io_lsu_wmask, 4'h0);
        check_eq("rst_wen", io_lsu_wen, 1'b0);
        check_eq("rst_ready_in_reset", req_ready, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        check_eq("ready_after_rst", req_ready, 1'b1);
        check_eq("bus_size", io_lsu_size, 2'd2);

        bus_wait = 2;
        exp_beat(32'h100, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF); exp_resp(32'hDEADBEEF, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b1); drain();
        bus_wait = 0;
        exp_beat(32'h100, 1'b0, 32'h0, 4'h0, 32'h8000_0000); exp_resp(32'hFFFF_FF80, 1'b0);
        issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1'b1); drain();
        exp_beat(32'h100, 1'b0, 32'h0, 4'h0, 32'h8000_0000); exp_resp(32'h0000_0080, 1'b0);
        issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 1'b1); drain();
        exp_beat(32'h100, 1'b1, 32'hABCD_0000, 4'hC, 32'h0); exp_resp(32'h0, 1'b0);
        issue(1'b1, 2'd1, 1'b0, 32'h102, 32'h1234_ABCD, 1'b1); drain();
        exp_beat(32'h100, 1'b1, 32'h4400_0000, 4'h8, 32'h0);
        exp_beat(32'h104, 1'b1, 32'h0011_2233, 4'h7, 32'h0); exp_resp(32'h0, 1'b0);
        issue(1'b1, 2'd2, 1'b0, 32'h103, 32'h1122_3344, 1'b1); drain();
        exp_beat(32'hFFFF_FFFC, 1'b0, 32'h0, 4'h0, 32'hAABB_0000);
        exp_beat(32'h0000_0000, 1'b0, 32'h0, 4'h0, 32'h0000_CCDD); exp_resp(32'hCCDD_AABB, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0, 1'b1); drain();
        exp_beat(32'h100, 1'b0, 32'h0, 4'h0, 32'h00AB_CD00); exp_resp(32'hFFFF_ABCD, 1'b0);
        issue(1'b0, 2'd1, 1'b1, 32'h101, 32'h0, 1'b1); drain();
        exp_beat(32'h100, 1'b1, 32'h0000_FF00, 4'h2, 32'h0); exp_resp(32'h0, 1'b0);
        issue(1'b1, 2'd0, 1'b0, 32'h101, 32'h0000_00FF, 1'b1); drain();
        exp_beat(32'h100, 1'b0, 32'h0, 4'h0, 32'h1200_0000);
        exp_beat(32'h104, 1'b0, 32'h0, 4'h0, 32'h0000_0034); exp_resp(32'h0000_3412, 1'b0);
        issue(1'b0, 2'd1, 1'b0, 32'h103, 32'h0, 1'b1); drain();
        exp_resp(32'h0, 1'b1);
        issue(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 1'b0); drain();

        // SPLIT=0 instance: crossing half load is an immediate error with no bus traffic.
        @(negedge clock);
        d0_req_valid = 1'b1;
        @(posedge clock);
        #1;
        d0_req_valid = 1'b0;
        check_eq("d0_resp_valid_T1", d0_resp_valid, 1'b1);
        check_eq("d0_resp_err_T1", d0_resp_err, 1'b1);
        check_eq("d0_resp_rdata", d0_resp_rdata, 32'h0);
        seen = d0_bus_req;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            seen = seen | d0_bus_req;
        end
        check_eq("d0_no_bus_traffic", seen, 1'b0);
        check_eq("d0_ready_again", d0_req_ready, 1'b1);

        // Reset while beat 0 is outstanding: beat abandoned, no response.
        bus_wait = 1000;
        issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 1'b1);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_eq("midrst_reqValid", io_lsu_reqValid, 1'b0);
        check_eq("midrst_resp_valid", resp_valid, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        bus_wait = 0;
        #1;
        check_eq("midrst_ready", req_ready, 1'b1);
        repeat (5) @(negedge clock);
        check_eq("midrst_quiet", resp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
